dbg_slave_cmd_sync: RTL

Parametrised system-clock command receiver for the on-chip debug slave. It takes the shift-register snapshot and update events produced in the JTAG TCK domain, brings them into `clk`, captures the data word, and decodes the instruction register into one-hot action / no-action pulses. It also adds a pending/ack handshake, overrun detection and an event counter that the fixed 2-bit/38-bit generation lacked. It sits between the virtual-JTAG TCK logic and the CPU debug/OCI-memory/trace-control logic.

---
 rtl/dbg_slave_cmd_sync_if.sv | 38 +++
 rtl/dbg_slave_cmd_sync.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dbg_slave_cmd_sync_if.sv
// Command bus between the virtual-JTAG TCK-side logic and the system-clock
// debug command receiver.
//   ir_in, sr          : instruction / shift-register snapshot (TCK domain)
//   uir_tgl, e1dr_tgl  : per-event toggles (TCK domain)
//   cmd_ack, ovr_clr   : consumer handshake / overrun clear (clk domain)
//   jdo, ir_q          : captured data word / instruction
//   take_action, take_no_action : one-hot decode pulses
//   cmd_valid, overrun, evt_cnt : pending flag, sticky drop flag, event count
interface dbg_slave_cmd_sync_if #(
    parameter int IR_W = 2,
    parameter int DR_W = 38
);
    localparam int N_CMD = 2 ** IR_W;

    logic [IR_W-1:0]  ir_in;
    logic [DR_W-1:0]  sr;
    logic             uir_tgl;
    logic             e1dr_tgl;
    logic             cmd_ack;
    logic             ovr_clr;
    logic [DR_W-1:0]  jdo;
    logic [IR_W-1:0]  ir_q;
    logic [N_CMD-1:0] take_action;
    logic [N_CMD-1:0] take_no_action;
    logic             cmd_valid;
    logic             overrun;
    logic [7:0]       evt_cnt;

    modport master (
        output ir_in, sr, uir_tgl, e1dr_tgl, cmd_ack, ovr_clr,
        input  jdo, ir_q, take_action, take_no_action, cmd_valid, overrun, evt_cnt
    );

    modport slave (
        input  ir_in, sr, uir_tgl, e1dr_tgl, cmd_ack, ovr_clr,
        output jdo, ir_q, take_action, take_no_action, cmd_valid, overrun, evt_cnt
    );
endinterface

// File: rtl/dbg_slave_cmd_sync.sv
// System-clock command receiver for the on-chip debug slave.
// Synchronises the Update-IR / Exit1-DR toggles from TCK into clk, captures
// the instruction and data word, and issues a one-hot action / no-action
// pulse per accepted command. Commands are held pending (cmd_valid) until
// acknowledged; an Exit1-DR event arriving while one is pending is dropped
// and flagged in the sticky overrun bit.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : command interface (slave side), see dbg_slave_cmd_sync_if
module dbg_slave_cmd_sync #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int ACT_BIT     = 35,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    dbg_slave_cmd_sync_if.slave bus
);
    localparam int N_CMD = 2 ** IR_W;
    localparam int ARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] uir_sync;
    logic [SYNC_STAGES-1:0] e1dr_sync;
    logic                   uir_prev;
    logic                   e1dr_prev;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;

    logic                   uir_evt;
    logic                   e1dr_evt;
    logic                   accept;
    logic                   drop;

    logic [DR_W-1:0]        jdo_r;
    logic [IR_W-1:0]        ir_r;
    logic                   fire;
    logic [N_CMD-1:0]       act_r;
    logic [N_CMD-1:0]       noact_r;
    logic                   valid_r;
    logic                   ovr_r;
    logic [7:0]             cnt_r;
    logic [N_CMD-1:0]       dec;

    // Toggle synchronisers. prev always follows sync_out; the arm counter
    // only masks the resulting edge for the first SYNC_STAGES+1 cycles so a
    // toggle that is already high at reset release is absorbed silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync  <= '0;
            e1dr_sync <= '0;
            uir_prev  <= 1'b0;
            e1dr_prev <= 1'b0;
            arm_cnt   <= '0;
        end else begin
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], bus.uir_tgl};
            e1dr_sync <= {e1dr_sync[SYNC_STAGES-2:0], bus.e1dr_tgl};
            uir_prev  <= uir_sync[SYNC_STAGES-1];
            e1dr_prev <= e1dr_sync[SYNC_STAGES-1];
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign armed    = (arm_cnt == ARM_DONE);
    assign uir_evt  = armed & (uir_sync[SYNC_STAGES-1] ^ uir_prev);
    assign e1dr_evt = armed & (e1dr_sync[SYNC_STAGES-1] ^ e1dr_prev);

    // An ack in the same cycle frees the slot, so the new event is taken.
    assign accept = e1dr_evt & (~valid_r | bus.cmd_ack);
    assign drop   = e1dr_evt & valid_r & ~bus.cmd_ack;

    // Decode reads ir_q one cycle after capture, so a uir event landing on
    // the same edge as the accept is already reflected.
    assign dec = N_CMD'(1) << ir_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_r   <= '0;
            ir_r    <= '0;
            fire    <= 1'b0;
            act_r   <= '0;
            noact_r <= '0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            if (uir_evt) ir_r <= bus.ir_in;

            fire <= accept;
            if (accept) begin
                jdo_r <= bus.sr;
                cnt_r <= cnt_r + 8'd1;
            end

            act_r   <= (fire &  jdo_r[ACT_BIT]) ? dec : '0;
            noact_r <= (fire & ~jdo_r[ACT_BIT]) ? dec : '0;

            if (accept)
                valid_r <= 1'b1;
            else if (bus.cmd_ack)
                valid_r <= 1'b0;

            // Set dominates clear.
            if (drop)
                ovr_r <= 1'b1;
            else if (bus.ovr_clr)
                ovr_r <= 1'b0;
        end
    end

    assign bus.jdo            = jdo_r;
    assign bus.ir_q           = ir_r;
    assign bus.take_action    = act_r;
    assign bus.take_no_action = noact_r;
    assign bus.cmd_valid      = valid_r;
    assign bus.overrun        = ovr_r;
    assign bus.evt_cnt        = cnt_r;
endmodule
